seq_div_16bit: RTL and testbench

- Iterative unsigned restoring divider: computes quotient and remainder by trial subtraction, one quotient bit per cycle.
- Subtraction is the inverse operation of the team's 16-bit ripple-carry adder. The trial subtract is a WIDTH+1-bit add of the inverted divisor with carry-in 1.
- Sits beside the ALU as a multi-cycle functional unit, driven by a start/done handshake from the pipeline's execute stage.

---
 rtl/seq_div_16bit.sv | 120 ++++++++++++
 tb/tb_seq_div_16bit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16bit.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Trial subtraction is a WIDTH+1-bit add of the inverted divisor with carry-in 1.
module seq_div_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] prem_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   dvs_inv;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic             accept;
  logic             zero_div;

  assign accept   = (state_reg == S_IDLE) && start;
  assign zero_div = (divisor == '0);

  // Zero-extended divisor, inverted bit by bit for the subtract-by-add.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_inv
      assign dvs_inv[gi] = ~dvs_reg[gi];
    end
  endgenerate
  assign dvs_inv[WIDTH] = 1'b1;

  assign shifted = {prem_reg, dvd_reg[WIDTH-1]};
  assign trial   = shifted + dvs_inv + {{WIDTH{1'b0}}, 1'b1};
  assign qbit    = ~trial[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = zero_div ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_reg == '0) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == S_CALC);
    done = (state_reg == S_DONE);
  end

  // Datapath; result outputs only move when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      prem_reg    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        dvd_reg  <= dividend;
        dvs_reg  <= divisor;
        prem_reg <= '0;
        cnt_reg  <= CNT_W'(WIDTH - 1);
      end
    end else if (state_reg == S_CALC) begin
      dvd_reg  <= {dvd_reg[WIDTH-2:0], qbit};
      prem_reg <= qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end else begin
        quotient    <= {dvd_reg[WIDTH-2:0], qbit};
        remainder   <= qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div_16bit.sv
// Self-checking bench for seq_div_16bit: directed scenarios plus a random back-to-back sweep
// compared against plain-arithmetic division.
module tb_seq_div_16bit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_div_16bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: ordinary integer division, with the divide-by-zero convention.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Issues one operation from a negedge in IDLE; returns at the negedge where done is seen.
  // lat counts rising edges after the accepting edge (done cycle = lat + 1).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat, output int busy_cnt, output logic timeout);
    if (done) @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    timeout = !done;
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
    end
    checks++;
    if ({quotient, remainder} !== {2*W{1'b0}}) begin
      errors++;
      $display("FAIL reset_results q=%h r=%h expected 0/0", quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle busy/done=%b expected 00", {busy, done});
    end
    $display("reset released, idle");
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r;
    logic z, to;
    int lat, bc;
    run_op(16'd100, 16'd7, q, r, z, lat, bc, to);
    $display("op 100/7 -> q=%0d r=%0d dbz=%0b done_cycle=%0d busy_cycles=%0d", q, r, z, lat + 1, bc);
    checks++;
    if (to !== 1'b0 || lat != W) begin
      errors++;
      $display("FAIL basic_latency done_cycle=%0d timeout=%0b expected %0d", lat + 1, to, W + 1);
    end
    checks++;
    if (bc != W) begin
      errors++;
      $display("FAIL basic_busy busy_cycles=%0d expected %0d", bc, W);
    end
    checks++;
    if ({q, r, z} !== {16'd14, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL basic_result q=%0d r=%0d dbz=%0b expected 14/2/0", q, r, z);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W-1:0] eq [4];
    logic [W-1:0] er [4];
    logic [W-1:0] q, r;
    logic z, to;
    int lat, bc;
    ta = '{16'hFFFF, 16'hFFFF, 16'd3,  16'd0};
    tb = '{16'h0001, 16'h8001, 16'd10, 16'd5};
    eq = '{16'hFFFF, 16'h0001, 16'd0,  16'd0};
    er = '{16'h0000, 16'h7FFE, 16'd3,  16'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], q, r, z, lat, bc, to);
      $display("op %h/%h -> q=%h r=%h dbz=%0b", ta[i], tb[i], q, r, z);
      checks++;
      if (to !== 1'b0 || {q, r, z} !== {eq[i], er[i], 1'b0}) begin
        errors++;
        $display("FAIL edge_%0d q=%h r=%h dbz=%0b to=%0b expected %h/%h/0", i, q, r, z, to, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic z, to;
    int lat, bc;
    run_op(16'd5, 16'd0, q, r, z, lat, bc, to);
    $display("op 5/0 -> q=%h r=%0d dbz=%0b done_cycle=%0d", q, r, z, lat + 1);
    checks++;
    if (to !== 1'b0 || lat != 0 || bc != 0) begin
      errors++;
      $display("FAIL dbz_latency done_cycle=%0d busy_cycles=%0d expected 1/0", lat + 1, bc);
    end
    checks++;
    if ({q, r, z} !== {16'hFFFF, 16'd5, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result q=%h r=%0d dbz=%0b expected ffff/5/1", q, r, z);
    end
    run_op(16'd9, 16'd3, q, r, z, lat, bc, to);
    $display("op 9/3 -> q=%0d r=%0d dbz=%0b", q, r, z);
    checks++;
    if (to !== 1'b0 || {q, r, z} !== {16'd3, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL dbz_clear q=%0d r=%0d dbz=%0b expected 3/0/0", q, r, z);
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] q, r;
    logic z, to;
    int lat, bc, pulses;
    if (done) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd10;
    @(posedge clk);
    @(negedge clk);
    dividend = 16'd7;
    divisor  = 16'd7;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    pulses = done ? 1 : 0;
    $display("op 1000/10 (start held) -> q=%0d r=%0d dbz=%0b done_cycle=%0d", quotient, remainder, div_by_zero, lat + 1);
    checks++;
    if (!done || lat != W || {quotient, remainder, div_by_zero} !== {16'd100, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL busy_ignore q=%0d r=%0d dbz=%0b done_cycle=%0d expected 100/0/0 at %0d",
               quotient, remainder, div_by_zero, lat + 1, W + 1);
    end
    // start still high across the DONE edge: must land in IDLE, not CALC
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL done_ignore busy/done=%b expected 00", {busy, done});
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse pulses=%0d busy=%0b expected 1/0", pulses, busy);
    end
    run_op(16'd7, 16'd7, q, r, z, lat, bc, to);
    $display("op 7/7 (re-asserted in idle) -> q=%0d r=%0d", q, r);
    checks++;
    if (to !== 1'b0 || lat != W || {q, r, z} !== {16'd1, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL restart_idle q=%0d r=%0d dbz=%0b to=%0b expected 1/0/0", q, r, z, to);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    logic z, to;
    int lat, bc, pulses;
    if (done) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd50000;
    divisor  = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset asserted in 8th calc cycle");
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || {quotient, remainder} !== {2*W{1'b0}}) begin
      errors++;
      $display("FAIL mid_reset busy=%0b done=%0b dbz=%0b q=%h r=%h expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_reset_hold active_cycles=%0d expected 0", pulses);
    end
    rst_n = 1'b1;
    run_op(16'd50000, 16'd3, q, r, z, lat, bc, to);
    $display("op 50000/3 after reset -> q=%0d r=%0d dbz=%0b", q, r, z);
    checks++;
    if (to !== 1'b0 || lat != W || {q, r, z} !== {16'd16666, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL post_reset q=%0d r=%0d dbz=%0b done_cycle=%0d expected 16666/2/0 at %0d",
               q, r, z, lat + 1, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, q, r, eq, er;
    logic z, ez, to;
    int lat, bc, mode;
    for (int n = 0; n < 2500; n++) begin
      a = W'($urandom);
      mode = $urandom_range(0, 7);
      case (mode)
        0:       b = '0;
        1:       b = W'($urandom_range(32768, 65535));
        2:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      run_op(a, b, q, r, z, lat, bc, to);
      ref_div(a, b, eq, er, ez);
      $display("rand %0d: %h/%h -> q=%h r=%h dbz=%0b", n, a, b, q, r, z);
      checks++;
      if (to !== 1'b0 || lat != ((b == 0) ? 0 : W)) begin
        errors++;
        $display("FAIL rand_latency %h/%h done_cycle=%0d to=%0b", a, b, lat + 1, to);
      end
      checks++;
      if ({q, r, z} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL rand_result %h/%h got %h/%h/%0b expected %h/%h/%0b", a, b, q, r, z, eq, er, ez);
      end
      if (b != 0) begin
        checks++;
        if ((32'(q) * 32'(b) + 32'(r)) != 32'(a) || r >= b) begin
          errors++;
          $display("FAIL rand_invariant %h/%h q=%h r=%h", a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
